// File: rtl/pc_debug_serializer.sv
// Debug word serializer: a DEPTH-entry FIFO feeding a single-wire MSB-first line.
// Each frame is one START pulse, DATA_W data bits and GAP idle cycles.
module pc_debug_serializer #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4,
  parameter int GAP       = 1,
  parameter int OVERWRITE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sleep,
  input  logic                       debug_enq_valid,
  input  logic [DATA_W-1:0]          debug_w_data,
  output logic                       debug_serial_out,
  output logic                       finish_status,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [7:0]                 overflow_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int CNT_W = (DATA_W + GAP > 1) ? $clog2(DATA_W + GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_GAP
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;

  logic full, empty, pop, push_ok, ovf_evt, drop_oldest, mem_we;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // A pop on this edge frees a slot, so a push to a full FIFO only overflows without one.
  assign push_ok     = debug_enq_valid && (!full || pop);
  assign ovf_evt     = debug_enq_valid && full && !pop;
  assign drop_oldest = ovf_evt && (OVERWRITE != 0);
  assign mem_we      = !rst && !sleep && (push_ok || drop_oldest);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        state_nxt = S_DATA;
        cnt_nxt   = '0;
      end
      S_DATA: begin
        if (cnt == CNT_W'(DATA_W - 1)) begin
          cnt_nxt = '0;
          if (GAP > 0) begin
            state_nxt = S_GAP;
          end else if (!empty) begin
            pop       = 1'b1;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == CNT_W'(GAP - 1)) begin
          cnt_nxt = '0;
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      shreg        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow_cnt <= '0;
    end else if (sleep) begin
      state  <= S_IDLE;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (pop)
        shreg <= mem[rd_ptr[AW-1:0]];
      else if (state == S_DATA)
        shreg <= shreg << 1;
      if (push_ok || drop_oldest)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop || drop_oldest)
        rd_ptr <= rd_ptr + 1'b1;
      if (ovf_evt && overflow_cnt != 8'hFF)
        overflow_cnt <= overflow_cnt + 8'd1;
    end
  end

  // NOTE: storage array has no reset; empty pointers make stale contents unobservable.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[wr_ptr[AW-1:0]] <= debug_w_data;
  end

  assign fifo_level       = wr_ptr - rd_ptr;
  assign debug_serial_out = (state == S_START) || ((state == S_DATA) && shreg[DATA_W-1]);
  assign busy             = (state != S_IDLE);
  assign finish_status    = (state == S_IDLE) && empty;

endmodule

// File: tb/tb_pc_debug_serializer.sv
// Directed bench for pc_debug_serializer: three instances cover default, drop-new and
// narrow gapless configurations; a line monitor decodes frames for comparison.
module tb_pc_debug_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst, sleep;
  logic        ab_valid;
  logic [31:0] ab_data;
  logic        c_valid;
  logic [7:0]  c_data;

  logic        a_line, a_fin, a_busy;
  logic [2:0]  a_level;
  logic [7:0]  a_ovf;
  logic        b_line, b_fin, b_busy;
  logic [2:0]  b_level;
  logic [7:0]  b_ovf;
  logic        c_line, c_fin, c_busy;
  logic [1:0]  c_level;
  logic [7:0]  c_ovf;

  pc_debug_serializer u_a (
    .clk(clk), .rst(rst), .sleep(sleep),
    .debug_enq_valid(ab_valid), .debug_w_data(ab_data),
    .debug_serial_out(a_line), .finish_status(a_fin), .busy(a_busy),
    .fifo_level(a_level), .overflow_cnt(a_ovf)
  );

  pc_debug_serializer #(.OVERWRITE(0)) u_b (
    .clk(clk), .rst(rst), .sleep(sleep),
    .debug_enq_valid(ab_valid), .debug_w_data(ab_data),
    .debug_serial_out(b_line), .finish_status(b_fin), .busy(b_busy),
    .fifo_level(b_level), .overflow_cnt(b_ovf)
  );

  pc_debug_serializer #(.DATA_W(8), .DEPTH(2), .GAP(0), .OVERWRITE(0)) u_c (
    .clk(clk), .rst(rst), .sleep(sleep),
    .debug_enq_valid(c_valid), .debug_w_data(c_data),
    .debug_serial_out(c_line), .finish_status(c_fin), .busy(c_busy),
    .fifo_level(c_level), .overflow_cnt(c_ovf)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Frame decoder: a rising line while busy and outside a frame is a START pulse.
  logic [31:0] qa[$], qb[$], qc[$];
  int          qc_start[$];

  initial begin
    int          pos [3];
    logic [31:0] sh  [3];
    logic        ln, bz;
    int          dw;
    for (int i = 0; i < 3; i++) pos[i] = -1;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        ln = (i == 0) ? a_line : (i == 1) ? b_line : c_line;
        bz = (i == 0) ? a_busy : (i == 1) ? b_busy : c_busy;
        dw = (i == 2) ? 8 : 32;
        if (!bz) begin
          pos[i] = -1;
        end else if (pos[i] < 0) begin
          if (ln) begin
            pos[i] = 0;
            sh[i]  = '0;
            if (i == 2) qc_start.push_back(cyc);
          end
        end else begin
          sh[i] = {sh[i][30:0], ln};
          pos[i]++;
          if (pos[i] == dw) begin
            case (i)
              0:       qa.push_back(sh[i]);
              1:       qb.push_back(sh[i]);
              default: qc.push_back(sh[i]);
            endcase
            pos[i] = -1;
          end
        end
      end
    end
  end

  task automatic wait_finish(input string tag, input int sel, input int budget);
    int   n = 0;
    logic f;
    f = (sel == 0) ? a_fin : (sel == 1) ? b_fin : c_fin;
    while (!f && n < budget) begin
      @(negedge clk);
      n++;
      f = (sel == 0) ? a_fin : (sel == 1) ? b_fin : c_fin;
    end
    check(tag, 32'(f), 32'd1);
  endtask

  task automatic collect32(output logic [31:0] w);
    w = '0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      w = {w[30:0], a_line};
    end
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] exp_a [5];
    logic [31:0] exp_b [5];
    logic [7:0]  exp_c [5];

    rst = 1'b1; sleep = 1'b0; ab_valid = 1'b0; ab_data = '0; c_valid = 1'b0; c_data = '0;
    repeat (3) @(negedge clk);
    check("rst_line",  32'(a_line),  32'd0);
    check("rst_busy",  32'(a_busy),  32'd0);
    check("rst_level", 32'(a_level), 32'd0);
    check("rst_ovf",   32'(a_ovf),   32'd0);
    check("rst_fin",   32'(a_fin),   32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Single word 0x8000_0001
    ab_valid = 1'b1; ab_data = 32'h8000_0001;
    @(negedge clk);                              // cycle t
    ab_valid = 1'b0;
    check("t1_level_t", 32'(a_level), 32'd1);
    @(negedge clk);                              // cycle t+1
    check("t1_start",   32'(a_line),  32'd1);
    check("t1_level_t1", 32'(a_level), 32'd0);
    collect32(w);                                // cycles t+2..t+33
    check("t1_word", w, 32'h8000_0001);
    @(negedge clk);                              // cycle t+34
    check("t1_gap_line", 32'(a_line), 32'd0);
    check("t1_gap_busy", 32'(a_busy), 32'd1);
    check("t1_gap_fin",  32'(a_fin),  32'd0);
    @(negedge clk);                              // cycle t+35
    check("t1_fin",  32'(a_fin),  32'd1);
    check("t1_idle", 32'(a_busy), 32'd0);

    // Back-to-back frames
    ab_valid = 1'b1; ab_data = 32'hFFFF_FFFF;
    @(negedge clk);                              // cycle t
    ab_data = 32'h0000_0000;
    check("t2_level_t", 32'(a_level), 32'd1);
    @(negedge clk);                              // cycle t+1
    ab_valid = 1'b0;
    check("t2_level_t1", 32'(a_level), 32'd1);
    check("t2_start1",   32'(a_line),  32'd1);
    collect32(w);
    check("t2_word1", w, 32'hFFFF_FFFF);
    @(negedge clk);                              // cycle t+34
    check("t2_gap", 32'(a_line), 32'd0);
    @(negedge clk);                              // cycle t+35
    check("t2_start2",      32'(a_line),  32'd1);
    check("t2_start2_busy", 32'(a_busy),  32'd1);
    check("t2_level_t35",   32'(a_level), 32'd0);
    collect32(w);
    check("t2_word2", w, 32'h0000_0000);
    wait_finish("t2_done", 0, 10);
    repeat (2) @(negedge clk);
    qa.delete(); qb.delete();

    // Overflow policy: six pushes 0xA0..0xA5
    ab_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ab_data = 32'hA0 + 32'(i);
      @(negedge clk);
    end
    ab_valid = 1'b0;                             // cycle t+5
    check("t3_ovf_a",   32'(a_ovf),   32'd1);
    check("t3_ovf_b",   32'(b_ovf),   32'd1);
    check("t3_level_a", 32'(a_level), 32'd4);
    check("t3_level_b", 32'(b_level), 32'd4);
    wait_finish("t3_done_a", 0, 300);
    wait_finish("t3_done_b", 1, 20);
    repeat (2) @(negedge clk);
    exp_a = '{32'hA0, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
    exp_b = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
    check("t3_nframes_a", 32'(qa.size()), 32'd5);
    check("t3_nframes_b", 32'(qb.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_a_frame%0d", i), (i < qa.size()) ? qa[i] : 32'hDEAD, exp_a[i]);
      check($sformatf("t3_b_frame%0d", i), (i < qb.size()) ? qb[i] : 32'hDEAD, exp_b[i]);
    end
    qa.delete(); qb.delete();

    // Sleep at data bit 10 with two words queued and a concurrent push
    ab_valid = 1'b1; ab_data = 32'h1111_1111;
    @(negedge clk);                              // cycle t
    ab_data = 32'h2222_2222;
    @(negedge clk);
    ab_data = 32'h3333_3333;
    @(negedge clk);                              // cycle t+2
    ab_valid = 1'b0;
    check("t4_level_q", 32'(a_level), 32'd2);
    repeat (10) @(negedge clk);                  // cycle t+12 = data bit 10
    check("t4_busy_pre", 32'(a_busy), 32'd1);
    sleep = 1'b1; ab_valid = 1'b1; ab_data = 32'h4444_4444;
    @(negedge clk);                              // cycle s
    sleep = 1'b0; ab_valid = 1'b0;
    check("t4_line",  32'(a_line),  32'd0);
    check("t4_busy",  32'(a_busy),  32'd0);
    check("t4_level", 32'(a_level), 32'd0);
    check("t4_fin",   32'(a_fin),   32'd1);
    check("t4_ovf",   32'(a_ovf),   32'd1);
    @(negedge clk);
    check("t4_level_after", 32'(a_level), 32'd0);
    check("t4_busy_after",  32'(a_busy),  32'd0);
    qa.delete(); qb.delete();

    // Narrow gapless drop-new: 300 pushes saturate overflow_cnt
    c_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      c_data = 8'(i);
      @(negedge clk);
    end
    c_valid = 1'b0;
    check("t5_ovf_sat", 32'(c_ovf),   32'd255);
    check("t5_level",   32'(c_level), 32'd2);
    wait_finish("t5_done", 2, 100);
    repeat (2) @(negedge clk);
    check("t5_nframes", 32'(qc.size()), 32'd36);
    exp_c = '{8'd0, 8'd1, 8'd2, 8'd10, 8'd19};
    for (int i = 0; i < 5; i++)
      check($sformatf("t5_frame%0d", i), (i < qc.size()) ? qc[i] : 32'hDEAD, 32'(exp_c[i]));
    for (int i = 1; i < 5; i++)
      check($sformatf("t5_period%0d", i),
            (i < qc_start.size()) ? 32'(qc_start[i] - qc_start[i-1]) : 32'hDEAD, 32'd9);

    // Reset mid-frame
    ab_valid = 1'b1; ab_data = 32'h1234_5678;
    @(negedge clk);
    ab_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_busy_pre", 32'(a_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_line",    32'(a_line),  32'd0);
    check("t6_busy",    32'(a_busy),  32'd0);
    check("t6_level",   32'(a_level), 32'd0);
    check("t6_fin",     32'(a_fin),   32'd1);
    check("t6_ovf_a",   32'(a_ovf),   32'd0);
    check("t6_ovf_c",   32'(c_ovf),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
    $finish;
  end

endmodule
